cpu6502_top: RTL and testbench
==============================

# cpu6502_top

Minimal 6502-subset system top: a multi-cycle CPU core executing 6502 load/store, JMP and NOP opcodes, plus a memory block instance `mem` holding a 4 KB ROM and a 2 KB RAM. It serves as the regression target for instruction-suite tests. Benches preload `mem.ROM` hierarchically, run the core, and check `mem.RAM` hierarchically.

## Interface
- No parameters.
- `ph1`  input  1  single system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- No other ports; observation is hierarchical.
  - `mem.ROM` is `reg [7:0] ROM [0:4095]`.
  - `mem.RAM` is `reg [7:0] RAM [0:2047]`.

## Operation
- **Address map (16-bit):**
  - `$0000-$07FF`: RAM, index = addr[10:0].
  - `$F000-$FFFF`: ROM, index = addr[11:0], read-only.
  - All other addresses read `$00`; writes to them are ignored.
- **Memory timing:**
  - Reads are combinational.
  - RAM writes commit on the `ph1` rising edge of the store's write cycle.
  - ROM has no synthesis init; contents come from a simulation preload only.
- **Reset vector:** `$FFFC` (ROM[4092]) is the low byte and `$FFFD` (ROM[4093]) the high byte. With `$00`/`$F0` preloaded, execution starts at `$F000`.
- **Registers:** A, X, Y, PC (16 bits) and flags N and Z.
- **Flag updates:** loads set Z = (result == 0) and N = result[7]. Stores, JMP and NOP leave flags unchanged.
- **Opcodes (hex):**
  - LDA: A9 imm, A5 zp, B5 zp,X, AD abs, BD abs,X, B9 abs,Y.
  - LDX: A2 imm, A6 zp, AE abs.
  - LDY: A0 imm, A4 zp, AC abs.
  - STA: 85 zp, 95 zp,X, 8D abs, 9D abs,X, 99 abs,Y.
  - STX: 86 zp, 8E abs.
  - STY: 84 zp, 8C abs.
  - JMP: 4C abs.
  - NOP: EA.
  - Any other opcode is executed as a 1-byte, 2-cycle NOP.
- **Effective-address rules:**
  - zp,X: (zp + X) mod 256, in page zero.
  - abs,X / abs,Y: 16-bit add, wraps at `$FFFF`.
  - Operands are little-endian.
- **FSM states:**
  - RST_LO → RST_HI → FETCH.
  - FETCH → OP1 (operand low byte / immediate).
  - OP1 → OP2 (absolute high byte) or MEM.
  - OP2 → MEM.
  - MEM → FETCH.
  - Immediate loads complete in OP1. JMP completes in OP2.

## Timing
- **While `reset`=0:** A=X=Y=0, N=Z=0, PC=`$0000`, state=RST_LO, no RAM writes. RAM contents are not cleared.
- **After reset release:**
  - Cycle 1 latches PC low from `$FFFC`.
  - Cycle 2 latches PC high from `$FFFD`.
  - Cycle 3 is the first FETCH.
- **Cycles per instruction (no page-cross penalty):**
  - Immediate: 2.
  - zp: 3.
  - zp,X: 4.
  - abs, abs,X, abs,Y (loads and stores): 4.
  - JMP: 3.
  - NOP / unknown opcode: 2.
- **Register and PC updates:**
  - Load results and flags update on the final cycle's edge.
  - PC increments once per byte fetched.
  - JMP loads PC on its last edge.
- **Reset mid-instruction:** takes effect immediately (asynchronously). Any in-progress store that has not reached its write edge is not written.
- **Self-loop:** `JMP` to its own address repeats forever with no memory writes, so a test can end in a stable state.

## Test plan
- **Reset vector:** ROM[4092]=`$00`, ROM[4093]=`$F0`, NOP at `$F000`, hold reset 5 cycles → PC=`$F000` at the first FETCH (third cycle after release).
- **Imm/abs load-store:** program `A9 55 8D 2A 02 4C 05 F0` at `$F000`, run 100 cycles → RAM[554]=`$55`, A=`$55`, N=0, Z=0, RAM otherwise unchanged.
- **X/Y loads and stores:**
  - `A2 80`, `86 10`: X=`$80`, N=1, then RAM[16]=`$80`.
  - `A0 00`, `84 11`: Y=0, Z=1, then RAM[17]=`$00`.
- **Indexed wrap and abs,Y:**
  - X=`$F0`, `95 20` → RAM[`$10`]=A (zp wrap).
  - `99 00 02` with Y=5 → RAM[517]=A.
- **Zero-page and absolute loads:** `A5 10` reads RAM[16]; `AD 2A 02` reads RAM[554]. Each updates A, N and Z.
- **Reset mid-program:** assert `reset` during the MEM cycle of `8D 2A 02` → RAM[554] unchanged; after release, execution restarts from the vector.

Source files
------------

// File: rtl/cpu6502_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu6502_top: 6502-subset core (load/store, JMP, NOP) with 4 KB ROM + 2 KB RAM |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module cpu6502_mem (
  input  logic        clk,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata
);
  logic [7:0] ROM [0:4095];
  logic [7:0] RAM [0:2047];
  logic       ram_sel;
  logic       rom_sel;

  assign ram_sel = (addr[15:11] == 5'b00000);
  assign rom_sel = (addr[15:12] == 4'hF);

  always_comb begin
    rdata = 8'h00;
    if (ram_sel) rdata = RAM[addr[10:0]];
    else if (rom_sel) rdata = ROM[addr[11:0]];
  end

  always_ff @(posedge clk) begin
    if (we && ram_sel) RAM[addr[10:0]] <= wdata;
  end
endmodule

module cpu6502_top (
  input logic ph1,
  input logic reset
);
  typedef enum logic [2:0] {RST_LO, RST_HI, FETCH, OP1, OP2, MEM} state_t;
  typedef enum logic [2:0] {M_NOP, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABSX, M_ABSY, M_JMP} mode_t;
  typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

  state_t      state, next_state;
  mode_t       mode;
  reg_t        sel;
  logic        is_store;
  logic [7:0]  ir, op_lo, op_hi;
  logic [15:0] pc, ea;
  logic [7:0]  a, x, y;
  logic        flag_n, flag_z;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, pc_inc, ld_en, sync;

  cpu6502_mem mem (
    .clk   (ph1),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .we    (mem_we),
    .rdata (mem_rdata)
  );

  always_comb begin
    mode     = M_NOP;
    sel      = R_A;
    is_store = 1'b0;
    case (ir)
      8'hA9: mode = M_IMM;
      8'hA5: mode = M_ZP;
      8'hB5: mode = M_ZPX;
      8'hAD: mode = M_ABS;
      8'hBD: mode = M_ABSX;
      8'hB9: mode = M_ABSY;
      8'hA2: begin mode = M_IMM; sel = R_X; end
      8'hA6: begin mode = M_ZP;  sel = R_X; end
      8'hAE: begin mode = M_ABS; sel = R_X; end
      8'hA0: begin mode = M_IMM; sel = R_Y; end
      8'hA4: begin mode = M_ZP;  sel = R_Y; end
      8'hAC: begin mode = M_ABS; sel = R_Y; end
      8'h85: begin mode = M_ZP;   is_store = 1'b1; end
      8'h95: begin mode = M_ZPX;  is_store = 1'b1; end
      8'h8D: begin mode = M_ABS;  is_store = 1'b1; end
      8'h9D: begin mode = M_ABSX; is_store = 1'b1; end
      8'h99: begin mode = M_ABSY; is_store = 1'b1; end
      8'h86: begin mode = M_ZP;  sel = R_X; is_store = 1'b1; end
      8'h8E: begin mode = M_ABS; sel = R_X; is_store = 1'b1; end
      8'h84: begin mode = M_ZP;  sel = R_Y; is_store = 1'b1; end
      8'h8C: begin mode = M_ABS; sel = R_Y; is_store = 1'b1; end
      8'h4C: mode = M_JMP;
      default: mode = M_NOP;
    endcase
  end

  // zp,X stays in page zero because the 8-bit sum is self-determined
  always_comb begin
    case (mode)
      M_ZP:    ea = {8'h00, op_lo};
      M_ZPX:   ea = {8'h00, op_lo + x};
      M_ABSX:  ea = {op_hi, op_lo} + {8'h00, x};
      M_ABSY:  ea = {op_hi, op_lo} + {8'h00, y};
      default: ea = {op_hi, op_lo};
    endcase
  end

  always_comb begin
    case (sel)
      R_X:     mem_wdata = x;
      R_Y:     mem_wdata = y;
      default: mem_wdata = a;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) state <= RST_LO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_addr   = pc;
    mem_we     = 1'b0;
    pc_inc     = 1'b0;
    ld_en      = 1'b0;
    case (state)
      RST_LO: begin mem_addr = 16'hFFFC; next_state = RST_HI; end
      RST_HI: begin mem_addr = 16'hFFFD; next_state = FETCH; end
      FETCH:  begin pc_inc = 1'b1; next_state = OP1; end
      OP1: begin
        case (mode)
          M_NOP:   next_state = FETCH;
          M_IMM:   begin pc_inc = 1'b1; ld_en = 1'b1; next_state = FETCH; end
          M_ZP:    begin pc_inc = 1'b1; next_state = MEM; end
          default: begin pc_inc = 1'b1; next_state = OP2; end
        endcase
      end
      OP2: begin
        // zp,X spends OP2 as an index cycle without fetching
        if (mode == M_ZPX)      next_state = MEM;
        else if (mode == M_JMP) next_state = FETCH;
        else begin pc_inc = 1'b1; next_state = MEM; end
      end
      MEM: begin
        mem_addr   = ea;
        mem_we     = is_store;
        ld_en      = !is_store;
        next_state = FETCH;
      end
      default: next_state = RST_LO;
    endcase
  end

  assign sync = (state == FETCH);

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      pc     <= 16'h0000;
      a      <= 8'h00;
      x      <= 8'h00;
      y      <= 8'h00;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      ir     <= 8'h00;
      op_lo  <= 8'h00;
      op_hi  <= 8'h00;
    end else begin
      if (pc_inc) pc <= pc + 16'd1;
      case (state)
        RST_LO: pc[7:0]  <= mem_rdata;
        RST_HI: pc[15:8] <= mem_rdata;
        FETCH:  ir       <= mem_rdata;
        OP1:    op_lo    <= mem_rdata;
        OP2: begin
          if (mode == M_JMP) pc    <= {mem_rdata, op_lo};
          else               op_hi <= mem_rdata;
        end
        default: ;
      endcase
      if (ld_en) begin
        case (sel)
          R_X:     x <= mem_rdata;
          R_Y:     y <= mem_rdata;
          default: a <= mem_rdata;
        endcase
        flag_z <= (mem_rdata == 8'h00);
        flag_n <= mem_rdata[7];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cpu6502_top.sv
`default_nettype none
// Bench for cpu6502_top: ISA-level reference model feeds a scoreboard of
// per-instruction outcomes and bus writes; a monitor checks them as they occur.
module tb_cpu6502_top;
  logic ph1 = 1'b0;
  logic reset = 1'b0;
  always #5 ph1 = ~ph1;

  cpu6502_top dut (.ph1(ph1), .reset(reset));

  typedef struct {
    logic [15:0] pc;
    int          cyc;
    logic [7:0]  a, x, y;
    logic        n, z;
  } rec_t;

  rec_t        ins_q[$];
  logic [23:0] wr_q[$];
  logic [7:0]  rom_m [0:4095];
  logic [7:0]  ram_m [0:2047];
  logic [15:0] wp;
  int          checks = 0;
  int          failures = 0;
  bit          running = 0;
  bit          done = 0;
  bit          first_seen = 0;
  int          cnt = 0;
  int          since_rel = 0;
  rec_t        prev;

  logic [7:0] two_b   [0:10] = '{8'hA9, 8'hA5, 8'hB5, 8'hA2, 8'hA6, 8'hA0, 8'hA4, 8'h85, 8'h95, 8'h86, 8'h84};
  logic [7:0] three_b [0:9]  = '{8'hAD, 8'hBD, 8'hB9, 8'hAE, 8'hAC, 8'h8D, 8'h9D, 8'h99, 8'h8E, 8'h8C};
  logic [7:0] one_b   [0:5]  = '{8'hEA, 8'h02, 8'h1A, 8'hFF, 8'h00, 8'h60};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic logic [7:0] mrd(input logic [15:0] ad);
    if (ad < 16'h0800) return ram_m[ad[10:0]];
    if (ad >= 16'hF000) return rom_m[ad[11:0]];
    return 8'h00;
  endfunction

  task automatic mst(input logic [15:0] ad, input logic [7:0] v);
    wr_q.push_back({ad, v});
    if (ad < 16'h0800) ram_m[ad[10:0]] = v;
  endtask

  task automatic run_model();
    logic [15:0] pc, ab, zx;
    logic [7:0]  op, b1, b2, v;
    logic [7:0]  a = 8'h00, x = 8'h00, y = 8'h00;
    logic        n = 1'b0, z = 1'b0, ld, stop;
    int          len, cyc;
    rec_t        r;
    pc = {rom_m[4093], rom_m[4092]};
    for (int step = 0; step < 4000; step++) begin
      op = mrd(pc); b1 = mrd(pc + 16'd1); b2 = mrd(pc + 16'd2);
      ab = {b2, b1};
      zx = (16'(b1) + 16'(x)) % 256;
      len = 1; cyc = 2; ld = 0; stop = 0; v = 8'h00;
      case (op)
        8'hA9: begin v = b1; a = v; ld = 1; len = 2; end
        8'hA5: begin v = mrd({8'h00, b1}); a = v; ld = 1; len = 2; cyc = 3; end
        8'hB5: begin v = mrd(zx); a = v; ld = 1; len = 2; cyc = 4; end
        8'hAD: begin v = mrd(ab); a = v; ld = 1; len = 3; cyc = 4; end
        8'hBD: begin v = mrd(ab + 16'(x)); a = v; ld = 1; len = 3; cyc = 4; end
        8'hB9: begin v = mrd(ab + 16'(y)); a = v; ld = 1; len = 3; cyc = 4; end
        8'hA2: begin v = b1; x = v; ld = 1; len = 2; end
        8'hA6: begin v = mrd({8'h00, b1}); x = v; ld = 1; len = 2; cyc = 3; end
        8'hAE: begin v = mrd(ab); x = v; ld = 1; len = 3; cyc = 4; end
        8'hA0: begin v = b1; y = v; ld = 1; len = 2; end
        8'hA4: begin v = mrd({8'h00, b1}); y = v; ld = 1; len = 2; cyc = 3; end
        8'hAC: begin v = mrd(ab); y = v; ld = 1; len = 3; cyc = 4; end
        8'h85: begin mst({8'h00, b1}, a); len = 2; cyc = 3; end
        8'h95: begin mst(zx, a); len = 2; cyc = 4; end
        8'h8D: begin mst(ab, a); len = 3; cyc = 4; end
        8'h9D: begin mst(ab + 16'(x), a); len = 3; cyc = 4; end
        8'h99: begin mst(ab + 16'(y), a); len = 3; cyc = 4; end
        8'h86: begin mst({8'h00, b1}, x); len = 2; cyc = 3; end
        8'h8E: begin mst(ab, x); len = 3; cyc = 4; end
        8'h84: begin mst({8'h00, b1}, y); len = 2; cyc = 3; end
        8'h8C: begin mst(ab, y); len = 3; cyc = 4; end
        8'h4C: begin cyc = 3; stop = (ab == pc); end
        default: ;
      endcase
      if (ld) begin z = (v == 8'h00); n = (v >= 8'h80); end
      r.pc = pc; r.cyc = cyc; r.a = a; r.x = x; r.y = y; r.n = n; r.z = z;
      ins_q.push_back(r);
      if (stop) break;
      pc = (op == 8'h4C) ? ab : pc + 16'(len);
    end
  endtask

  // ---------------- program construction ----------------
  task automatic emit(input logic [7:0] b);
    rom_m[wp[11:0]] = b;
    wp = wp + 16'd1;
  endtask

  task automatic jmp_self();
    logic [15:0] t;
    t = wp;
    emit(8'h4C); emit(t[7:0]); emit(t[15:8]);
  endtask

  task automatic prep_rom(input logic [15:0] base);
    for (int i = 0; i < 4096; i++) rom_m[i] = 8'($urandom);
    rom_m[4092] = base[7:0];
    rom_m[4093] = base[15:8];
    wp = base;
  endtask

  function automatic logic [15:0] pick_abs();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 16'($urandom_range(0, 2047));
      6:       return 16'hF000 + 16'($urandom_range(0, 4095));
      7:       return 16'($urandom);
      8:       return {8'hFF, 8'($urandom)};
      default: return 16'h0200 + 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic gen_random(input int count);
    int s, k2;
    logic [15:0] t, ad;
    for (int k = 0; k < count; k++) begin
      s = $urandom_range(0, 19);
      if (s < 8) begin
        emit(two_b[$urandom_range(0, 10)]);
        emit(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      end else if (s < 16) begin
        emit(three_b[$urandom_range(0, 9)]);
        ad = pick_abs();
        emit(ad[7:0]); emit(ad[15:8]);
      end else if (s < 18) begin
        emit(one_b[$urandom_range(0, 5)]);
      end else begin
        k2 = $urandom_range(0, 3);
        t = wp + 16'd3 + 16'(k2);
        emit(8'h4C); emit(t[7:0]); emit(t[15:8]);
        repeat (k2) emit(8'($urandom));
      end
    end
    jmp_self();
  endtask

  task automatic load_dut_rom();
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = rom_m[i];
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge ph1);
    if (running) begin
      since_rel++;
      cnt++;
      if (dut.mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", dut.mem_addr, dut.mem_wdata);
        end else begin
          chk("store_bus", {8'h00, dut.mem_addr, dut.mem_wdata}, {8'h00, wr_q.pop_front()});
        end
      end
      if (dut.sync) begin
        if (!first_seen) begin
          chk("first_fetch_cycle", since_rel, 3);
          first_seen = 1;
        end else begin
          chk("cycles", cnt, prev.cyc);
          chk("reg_a", dut.a, prev.a);
          chk("reg_x", dut.x, prev.x);
          chk("reg_y", dut.y, prev.y);
          chk("flags_nz", {dut.flag_n, dut.flag_z}, {prev.n, prev.z});
        end
        cnt = 0;
        if (done || ins_q.size() == 0) begin
          done = 1;
          chk("self_loop_pc", dut.pc, prev.pc);
        end else begin
          prev = ins_q.pop_front();
          chk("fetch_pc", dut.pc, prev.pc);
        end
      end
    end
  end

  // ---------------- run one program through the scoreboard ----------------
  task automatic run_program(input int budget);
    int n, mism;
    reset = 1'b0;
    running = 0;
    repeat (5) @(posedge ph1);
    load_dut_rom();
    for (int i = 0; i < 2048; i++) ram_m[i] = dut.mem.RAM[i];
    ins_q.delete();
    wr_q.delete();
    run_model();
    done = 0; first_seen = 0; cnt = 0; since_rel = 0;
    @(posedge ph1);
    #2;
    reset = 1'b1;
    running = 1;
    n = 0;
    while (!done && n < budget) begin
      @(posedge ph1);
      n++;
    end
    chk("run_completes", {31'd0, done}, 32'd1);
    repeat (6) @(posedge ph1);
    @(negedge ph1);
    running = 0;
    chk("writes_drained", wr_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 2048; i++) begin
      if (dut.mem.RAM[i] !== ram_m[i]) begin
        if (mism == 0) $display("FAIL ram_byte[%0d] actual=%0h required=%0h", i, dut.mem.RAM[i], ram_m[i]);
        mism++;
      end
    end
    chk("ram_image", mism, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge ph1);
    #1;
    chk("reset_pc", dut.pc, 16'h0000);
    chk("reset_regs", {dut.a, dut.x, dut.y}, 24'h0);
    chk("reset_flags", {dut.flag_n, dut.flag_z}, 2'b00);
    chk("reset_no_write", {31'd0, dut.mem_we}, 32'd0);

    // imm/abs load-store ending in a self-loop
    prep_rom(16'hF000);
    emit(8'hA9); emit(8'h55); emit(8'h8D); emit(8'h2A); emit(8'h02); jmp_self();
    run_program(500);
    chk("p1_ram554", dut.mem.RAM[554], 8'h55);
    chk("p1_a", dut.a, 8'h55);
    chk("p1_nz", {dut.flag_n, dut.flag_z}, 2'b00);

    // reset asserted during the MEM cycle of the absolute store
    prep_rom(16'hF000);
    emit(8'hA9); emit(8'h33); emit(8'h8D); emit(8'h2A); emit(8'h02); jmp_self();
    reset = 1'b0;
    repeat (5) @(posedge ph1);
    load_dut_rom();
    @(posedge ph1);
    #2;
    reset = 1'b1;
    repeat (8) @(negedge ph1);
    chk("mid_store_we", {31'd0, dut.mem_we}, 32'd1);
    chk("mid_store_addr", dut.mem_addr, 16'h022A);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_pc", dut.pc, 16'h0000);
    chk("mid_reset_a", dut.a, 8'h00);
    repeat (3) @(posedge ph1);
    #1;
    chk("aborted_store", dut.mem.RAM[554], 8'h55);
    run_program(500);
    chk("restart_ram554", dut.mem.RAM[554], 8'h33);

    // X/Y load-store, zp,X wrap, abs,Y, zp and abs loads
    prep_rom(16'hF000);
    emit(8'hA2); emit(8'h80); emit(8'h86); emit(8'h10);
    emit(8'hA0); emit(8'h00); emit(8'h84); emit(8'h11);
    emit(8'hA5); emit(8'h10);
    emit(8'hA2); emit(8'hF0); emit(8'hA9); emit(8'h3C); emit(8'h95); emit(8'h20);
    emit(8'hA0); emit(8'h05); emit(8'h99); emit(8'h00); emit(8'h02);
    emit(8'hAD); emit(8'h2A); emit(8'h02);
    jmp_self();
    run_program(500);
    chk("p2_ram16", dut.mem.RAM[16], 8'h3C);
    chk("p2_ram17", dut.mem.RAM[17], 8'h00);
    chk("p2_ram517", dut.mem.RAM[517], 8'h3C);
    chk("p2_axy", {dut.a, dut.x, dut.y}, 24'h33F005);

    // randomized programs
    for (int r = 0; r < 6; r++) begin
      prep_rom(16'hF000 + 16'($urandom_range(0, 15) * 16));
      gen_random(40);
      run_program(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
